pll_reconfig_ctrl: RTL

Sequencer and dynamic-configuration controller for the Gowin rPLL. It runs on the board reference clock (27 MHz) and drives the PLL's RESET, IDSEL, FBDSEL and ODSEL inputs. It qualifies LOCK with a stable-time filter and a timeout/retry policy, and exposes a single `clk_ok` flag that gates release of downstream (DDR) logic. The PLL wrapper it drives must be instantiated with DYN_IDIV_SEL, DYN_FBDIV_SEL and DYN_ODIV_SEL set to "true".

---
 rtl/pll_reconfig_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: rPLL reset sequencer, lock qualifier and dynamic divider controller
// Ports:
//   clk, rst_n                 reference clock, async active-low reset
//   cfg_req/idiv/fbdiv/odsel   divider update request (level) and values; cfg_ack pulses on accept
//   pll_lock                   async PLL lock, synchronized internally
//   pll_reset, pll_*sel        PLL reset and dynamic divider selects (idsel/fbdsel inverted)
//   clk_ok, busy, fail         qualified clock, sequencing in progress, sticky failure
//   lock_lost                  pulse when lock drops while running
module pll_reconfig_ctrl #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_STABLE = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RETRIES = 3,
  parameter logic [5:0] DEF_IDIV = 6'd0,
  parameter logic [5:0] DEF_FBDIV = 6'd2,
  parameter logic [5:0] DEF_ODSEL = 6'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_req,
  input  logic [5:0] cfg_idiv,
  input  logic [5:0] cfg_fbdiv,
  input  logic [5:0] cfg_odsel,
  output logic       cfg_ack,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       clk_ok,
  output logic       busy,
  output logic       fail,
  output logic       lock_lost
);
  localparam int MAXC = (RESET_CYCLES > LOCK_STABLE) ?
    ((RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT) :
    ((LOCK_STABLE > LOCK_TIMEOUT) ? LOCK_STABLE : LOCK_TIMEOUT);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int TW = $clog2(RETRIES + 1);
  localparam logic [CW-1:0] RC_END = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] LS_END = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] LT_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TRY_MAX = TW'(RETRIES);
  typedef enum logic [2:0] {S_HOLD, S_WAIT, S_STABLE, S_RUN, S_FAIL} state_t;
  state_t state_q;
  logic lock_m_q, lock_s_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] try_q, try_d;
  logic pll_reset_q, clk_ok_q, busy_q, fail_q, ack_q, lost_q;
  logic [5:0] idsel_q, fbdsel_q, odsel_q;
  assign try_d = try_q + 1'b1;
  // Divider selects are only rewritten in the cfg_req branch, which also forces
  // pll_reset high on the same edge, so the PLL never sees them change while running.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
      state_q <= S_HOLD;
      cnt_q <= '0;
      try_q <= '0;
      pll_reset_q <= 1'b1;
      idsel_q <= ~DEF_IDIV;
      fbdsel_q <= ~DEF_FBDIV;
      odsel_q <= DEF_ODSEL;
      clk_ok_q <= 1'b0;
      busy_q <= 1'b1;
      fail_q <= 1'b0;
      ack_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      lock_m_q <= pll_lock;
      lock_s_q <= lock_m_q;
      ack_q <= 1'b0;
      lost_q <= 1'b0;
      if (cfg_req) begin
        ack_q <= 1'b1;
        idsel_q <= ~cfg_idiv;
        fbdsel_q <= ~cfg_fbdiv;
        odsel_q <= cfg_odsel;
        fail_q <= 1'b0;
        clk_ok_q <= 1'b0;
        try_q <= '0;
        cnt_q <= '0;
        state_q <= S_HOLD;
        pll_reset_q <= 1'b1;
        busy_q <= 1'b1;
      end else
        case (state_q)
          S_HOLD:
            if (cnt_q == RC_END) begin
              cnt_q <= '0;
              state_q <= S_WAIT;
              pll_reset_q <= 1'b0;
            end else cnt_q <= cnt_q + 1'b1;
          S_WAIT:
            if (lock_s_q) begin
              cnt_q <= '0;
              state_q <= S_STABLE;
            end else if (cnt_q == LT_END) begin
              cnt_q <= '0;
              try_q <= try_d;
              pll_reset_q <= 1'b1;
              if (try_d < TRY_MAX) state_q <= S_HOLD;
              else begin
                state_q <= S_FAIL;
                fail_q <= 1'b1;
                busy_q <= 1'b0;
              end
            end else cnt_q <= cnt_q + 1'b1;
          S_STABLE:
            if (!lock_s_q) begin
              cnt_q <= '0;
              state_q <= S_WAIT;
            end else if (cnt_q == LS_END) begin
              cnt_q <= '0;
              state_q <= S_RUN;
              clk_ok_q <= 1'b1;
              busy_q <= 1'b0;
            end else cnt_q <= cnt_q + 1'b1;
          S_RUN:
            if (!lock_s_q) begin
              lost_q <= 1'b1;
              clk_ok_q <= 1'b0;
              try_q <= '0;
              cnt_q <= '0;
              state_q <= S_HOLD;
              pll_reset_q <= 1'b1;
              busy_q <= 1'b1;
            end
          S_FAIL: ;
          default: begin
            state_q <= S_HOLD;
            cnt_q <= '0;
            pll_reset_q <= 1'b1;
            busy_q <= 1'b1;
          end
        endcase
    end
  assign cfg_ack = ack_q;
  assign pll_reset = pll_reset_q;
  assign pll_idsel = idsel_q;
  assign pll_fbdsel = fbdsel_q;
  assign pll_odsel = odsel_q;
  assign clk_ok = clk_ok_q;
  assign busy = busy_q;
  assign fail = fail_q;
  assign lock_lost = lost_q;
endmodule
